// File: rtl/svo_tmds_pkg.sv
// Shared types and TMDS constants for the video-period scheduler.
package svo_tmds_pkg;

  typedef enum logic [1:0] {
    StBlank,
    StPreamble,
    StGuard,
    StActive
  } state_e;

  // Video guard-band code words, ch0/ch2 identical.
  localparam logic [9:0] GuardBandCh0 = 10'b1011001100;
  localparam logic [9:0] GuardBandCh1 = 10'b0100110011;
  localparam logic [9:0] GuardBandCh2 = 10'b1011001100;

  // Video-data preamble: CTL0=1, CTL1..CTL3=0.
  localparam logic [1:0] CtlPreambleCh1 = 2'b01;
  localparam logic [1:0] CtlPreambleCh2 = 2'b00;

  localparam logic [9:0] CtrlCode00 = 10'b1101010100;
  localparam logic [9:0] CtrlCode01 = 10'b0010101011;
  localparam logic [9:0] CtrlCode10 = 10'b0101010100;
  localparam logic [9:0] CtrlCode11 = 10'b1010101011;

  function automatic logic [9:0] ctrl_code(input logic [1:0] ctrl);
    logic [9:0] code;
    unique case (ctrl)
      2'b00:   code = CtrlCode00;
      2'b01:   code = CtrlCode01;
      2'b10:   code = CtrlCode10;
      default: code = CtrlCode11;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/svo_tmds_delay.sv
// Fixed-depth shift-register delay line with asynchronous clear to zero.
module svo_tmds_delay #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] line_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) line_q[i] <= line_q[i-1];
    end
  end

  assign dout = line_q[DEPTH-1];

endmodule

// File: rtl/svo_tmds_sched.sv
// Schedules BLANK/PREAMBLE/GUARD/ACTIVE periods for three TMDS encoders.
// HDMI preamble/guard insertion is built only with SVO_HDMI_PREAMBLE_EN defined.
module svo_tmds_sched
  import svo_tmds_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_de,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic [23:0] in_rgb,
  output logic        out_de,
  output logic [1:0]  out_ctrl0,
  output logic [1:0]  out_ctrl1,
  output logic [1:0]  out_ctrl2,
  output logic [7:0]  out_din0,
  output logic [7:0]  out_din1,
  output logic [7:0]  out_din2,
  output logic        out_gb,
  output logic        err_short_blank
);

  if (PREAMBLE_LEN == 0 || PREAMBLE_LEN > 14) begin : g_len_check
    $error("svo_tmds_sched: PREAMBLE_LEN must be in 1..14");
  end

  state_e      state_d;
  logic        dly_hsync;
  logic        dly_vsync;
  logic [23:0] dly_rgb;

`ifdef SVO_HDMI_PREAMBLE_EN
  localparam int unsigned L     = PREAMBLE_LEN + 2;
  localparam int unsigned DistW = $clog2(L + 1);

  state_e           state_q;
  logic [L-1:0]     de_sr_q;
  logic [25:0]      dly_word;
  logic [DistW-1:0] dist;
  logic             dly_de;
  logic             short_d;
  logic             err_q;

  svo_tmds_delay #(
    .DEPTH(L),
    .WIDTH(26)
  ) u_delay (
    .clk   (clk),
    .resetn(resetn),
    .din   ({in_vsync, in_hsync, in_rgb}),
    .dout  (dly_word)
  );

  assign {dly_vsync, dly_hsync, dly_rgb} = dly_word;

  // de history: bit 0 newest, bit L-1 lines up with the delay-line output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) de_sr_q <= '0;
    else         de_sr_q <= {de_sr_q[L-2:0], in_de};
  end

  assign dly_de = de_sr_q[L-1];

  // Distance from the delayed sample to the nearest upcoming de; 0 = none within L.
  always_comb begin
    dist = '0;
    if (in_de) dist = DistW'(L);
    for (int k = int'(L) - 1; k >= 1; k--) begin
      if (de_sr_q[L-1-k]) dist = DistW'(k);
    end
  end

  always_comb begin
    state_d = StBlank;
    short_d = 1'b0;
    if (dly_de) begin
      state_d = StActive;
    end else if (dist == DistW'(1) && state_q == StActive) begin
      short_d = 1'b1;
    end else if (dist == DistW'(1) || dist == DistW'(2)) begin
      state_d = StGuard;
    end else if (dist != '0) begin
      state_d = StPreamble;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StBlank;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | short_d;
    end
  end

  assign err_short_blank = err_q;
`else
  assign dly_hsync       = in_hsync;
  assign dly_vsync       = in_vsync;
  assign dly_rgb         = in_rgb;
  assign state_d         = in_de ? StActive : StBlank;
  assign err_short_blank = 1'b0;
`endif

  logic [1:0]  ctrl1_d;
  logic [23:0] din_d;
  logic        gb_d;
  logic        de_d;

  always_comb begin
    ctrl1_d = 2'b00;
    din_d   = '0;
    gb_d    = 1'b0;
    de_d    = 1'b0;
    unique case (state_d)
      StPreamble: ctrl1_d = CtlPreambleCh1;
      StGuard:    gb_d    = 1'b1;
      StActive: begin
        de_d  = 1'b1;
        din_d = dly_rgb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_de    <= 1'b0;
      out_ctrl0 <= 2'b00;
      out_ctrl1 <= 2'b00;
      out_din0  <= 8'd0;
      out_din1  <= 8'd0;
      out_din2  <= 8'd0;
      out_gb    <= 1'b0;
    end else begin
      out_de    <= de_d;
      out_ctrl0 <= {dly_vsync, dly_hsync};
      out_ctrl1 <= ctrl1_d;
      out_din0  <= din_d[7:0];
      out_din1  <= din_d[15:8];
      out_din2  <= din_d[23:16];
      out_gb    <= gb_d;
    end
  end

  assign out_ctrl2 = CtlPreambleCh2;

endmodule

// File: tb/tb_svo_tmds_sched.sv
// Scoreboard bench for svo_tmds_sched; expectations follow the build's SVO_HDMI_PREAMBLE_EN.
module tb_svo_tmds_sched;

  localparam int PL = 8;
`ifdef SVO_HDMI_PREAMBLE_EN
  localparam int LP   = PL + 2;
  localparam bit HDMI = 1'b1;
`else
  localparam int LP   = 0;
  localparam bit HDMI = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        in_de;
  logic        in_hsync;
  logic        in_vsync;
  logic [23:0] in_rgb;
  logic        out_de;
  logic [1:0]  out_ctrl0;
  logic [1:0]  out_ctrl1;
  logic [1:0]  out_ctrl2;
  logic [7:0]  out_din0;
  logic [7:0]  out_din1;
  logic [7:0]  out_din2;
  logic        out_gb;
  logic        err_short_blank;

  svo_tmds_sched #(
    .PREAMBLE_LEN(PL)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_de          (in_de),
    .in_hsync       (in_hsync),
    .in_vsync       (in_vsync),
    .in_rgb         (in_rgb),
    .out_de         (out_de),
    .out_ctrl0      (out_ctrl0),
    .out_ctrl1      (out_ctrl1),
    .out_ctrl2      (out_ctrl2),
    .out_din0       (out_din0),
    .out_din1       (out_din1),
    .out_din2       (out_din2),
    .out_gb         (out_gb),
    .err_short_blank(err_short_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [32:0] outv;
  assign outv = {out_de, out_ctrl0, out_ctrl1, out_ctrl2, out_din2, out_din1, out_din0,
                 out_gb, err_short_blank};

  int n_checks = 0;
  int n_fail   = 0;
  int scen     = 0;

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Padded stimulus: LP leading zero samples stand for the cleared delay line.
  bit          pde [256];
  bit          phs [256];
  bit          pvs [256];
  logic [23:0] prgb[256];
  logic [32:0] pexp[256];
  int          np;
  logic [32:0] sb[$];

  task automatic seq_start();
    np = 0;
    for (int i = 0; i < LP; i++) begin
      pde[np] = 1'b0; phs[np] = 1'b0; pvs[np] = 1'b0; prgb[np] = '0;
      np++;
    end
  endtask

  task automatic add(input int cnt, input bit de);
    for (int i = 0; i < cnt; i++) begin
      pde[np]  = de;
      phs[np]  = 1'($urandom_range(0, 1));
      pvs[np]  = 1'($urandom_range(0, 1));
      prgb[np] = 24'($urandom);
      np++;
    end
  endtask

  // Reference: classify each blank sample by its run length N and position from the run's end.
  task automatic compute();
    bit err;
    err = 1'b0;
    for (int m = 0; m < np; m++) begin
      int e, s, nrun, r, nsat, pre;
      logic [1:0] c1;
      bit gb, sh, act;
      e = -1; s = -1; c1 = 2'b00; gb = 1'b0; sh = 1'b0; act = pde[m];
      if (!act && HDMI) begin
        for (int j = m + 1; j < np; j++) if (pde[j]) begin e = j; break; end
        for (int j = m - 1; j >= 0; j--) if (pde[j]) begin s = j; break; end
        if (e >= 0) begin
          nrun = (s < 0) ? 1000 : e - s - 1;
          r = e - m;
          if (nrun < 2) begin
            sh = 1'b1;
          end else begin
            nsat = (nrun < LP) ? nrun : LP;
            pre  = (nsat - 2 < PL) ? nsat - 2 : PL;
            if (r <= 2) gb = 1'b1;
            else if (r <= 2 + pre) c1 = 2'b01;
          end
        end
      end
      err = err | sh;
      pexp[m] = {act, pvs[m], phs[m], c1, 2'b00, act ? prgb[m] : 24'd0, gb, err};
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn = 1'b0; in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_rgb = '0;
    #1;
    check($sformatf("s%0d_reset", scen), outv, 33'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic run_seq(input int abort_at, input int count_len);
    int nd, k, first_de, cb, cp, cg, ca;
    logic [32:0] exp;
    nd = np - LP; first_de = -1; cb = 0; cp = 0; cg = 0; ca = 0;
    compute();
    sb.delete();
    for (int m = 0; m < LP; m++) sb.push_back(pexp[m]);
    for (int i = 0; i < nd; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
        if (first_de < 0 && out_de) first_de = i;
        k = i - 1 - LP;
        if (k >= 0 && k < count_len) begin
          if (out_de) ca++;
          else if (out_gb) cg++;
          else if (out_ctrl1 == 2'b01) cp++;
          else cb++;
        end
        if (sb.size() >= LP + 1) begin
          exp = sb.pop_front();
          check($sformatf("s%0d_i%0d", scen, i), outv, exp);
        end
        if (i == abort_at) begin
          resetn = 1'b0;
          #1;
          check($sformatf("s%0d_abort_rst", scen), outv, 33'd0);
          sb.delete();
          return;
        end
      end
      sb.push_back(pexp[LP+i]);
      in_de = pde[LP+i]; in_hsync = phs[LP+i]; in_vsync = pvs[LP+i]; in_rgb = prgb[LP+i];
    end
    if (count_len > 0) begin
      check("cnt_blank",    33'(cb), HDMI ? 33'd10 : 33'd20);
      check("cnt_preamble", 33'(cp), HDMI ? 33'd8 : 33'd0);
      check("cnt_guard",    33'(cg), HDMI ? 33'd2 : 33'd0);
      check("cnt_active",   33'(ca), 33'd5);
      check("first_de_cyc", 33'(first_de), 33'(20 + LP + 1));
    end
  endtask

  initial begin
    resetn = 1'b0; in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_rgb = '0;

    // Long blank then a short active run.
    scen = 1; do_reset(); seq_start();
    add(20, 0); add(5, 1); add(12, 0);
    run_seq(-1, 25);

    // 5-cycle gap between runs.
    scen = 2; do_reset(); seq_start();
    add(12, 0); add(4, 1); add(5, 0); add(4, 1); add(12, 0);
    run_seq(-1, 0);

    // 1-cycle gap (sticky error), then 1-cycle run and a 2-cycle gap.
    scen = 3; do_reset(); seq_start();
    add(12, 0); add(3, 1); add(1, 0); add(3, 1); add(6, 0); add(1, 1);
    add(2, 0); add(2, 1); add(12, 0);
    run_seq(-1, 0);

    // de already high at reset release.
    scen = 4; do_reset(); seq_start();
    add(4, 1); add(3, 0); add(4, 1); add(12, 0);
    run_seq(-1, 0);

    // Reset asserted mid-active run.
    scen = 5; do_reset(); seq_start();
    add(12, 0); add(20, 1); add(8, 0);
    run_seq(25, 0);

    // Normal operation after the aborted run.
    scen = 6; do_reset(); seq_start();
    add(12, 0); add(5, 1); add(12, 0);
    run_seq(-1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
